cordic_seq_ctrl: RTL and testbench

Iterative rotation-mode CORDIC sequencer that computes cosine and sine of a signed angle. It steps through up to 32 micro-rotations, one per clock, and drives the iteration index to the external combinational arctangent table (`cordic_atan` table, Q0.32 radians). Upstream and downstream connect through valid/ready handshakes. It is the control and datapath core of the CORDIC unit.

---
 rtl/cordic_seq_ctrl_if.sv | 37 +++
 rtl/cordic_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_cordic_seq_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_seq_ctrl_if
//  Description : Handshake and table-lookup bundle for the CORDIC sequencer.
//                master side = upstream/downstream/table owner,
//                slave side  = the sequencer core.
//  Signals     : in_valid/in_ready/angle_in   - angle input handshake
//                abort                        - cancel current operation
//                lut_iter/lut_atan            - arctangent table lookup
//                out_valid/out_ready          - result handshake
//                cos_out/sin_out/range_err    - result payload
//  Revision    : 1.0 - initial release
// ============================================================================
interface cordic_seq_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [33:0] angle_in;
   logic        abort;
   logic [4:0]  lut_iter;
   logic [31:0] lut_atan;
   logic        out_valid;
   logic        out_ready;
   logic [33:0] cos_out;
   logic [33:0] sin_out;
   logic        range_err;

   modport master (
      output in_valid, angle_in, abort, out_ready, lut_atan,
      input  in_ready, lut_iter, out_valid, cos_out, sin_out, range_err
   );

   modport slave (
      input  in_valid, angle_in, abort, out_ready, lut_atan,
      output in_ready, lut_iter, out_valid, cos_out, sin_out, range_err
   );
endinterface
`default_nettype wire

// File: rtl/cordic_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_seq_ctrl
//  Description : Iterative rotation-mode CORDIC sequencer producing cos/sin
//                of a signed Q2.32 angle, one micro-rotation per clock.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - cordic_seq_ctrl_if.slave (handshakes, table lookup,
//                       results)
//  Parameters  : ITERATIONS - micro-rotations per operation (1..32)
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_seq_ctrl #(
   parameter int ITERATIONS = 32
) (
   input  wire logic         clk,
   input  wire logic         rst,
   cordic_seq_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // CORDIC gain compensation K and the pi/2 clamp bound, both Q2.32.
   localparam logic signed [33:0] K_INIT = 34'sh09B74EDA8;
   localparam logic signed [33:0] BOUND  = 34'sh1921FB544;
   localparam logic [4:0]         LAST   = 5'(ITERATIONS - 1);

   state_t             state;
   logic signed [33:0] x, y, z;
   logic [4:0]         iter;
   logic               in_ready_r;
   logic               out_valid_r;
   logic [33:0]        cos_r, sin_r;
   logic               range_err_r;

   // Input clamp to +/- pi/2.
   logic signed [33:0] angle;
   logic               over_pos, over_neg;
   logic signed [33:0] angle_clamped;

   always_comb begin
      angle         = $signed(bus.angle_in);
      over_pos      = (angle > BOUND);
      over_neg      = (angle < -BOUND);
      angle_clamped = angle;
      if (over_pos) angle_clamped = BOUND;
      if (over_neg) angle_clamped = -BOUND;
   end

   // One micro-rotation; direction follows the sign of the residual angle.
   logic signed [33:0] x_shift, y_shift, atan_ext;
   logic signed [33:0] x_next, y_next, z_next;

   always_comb begin
      x_shift  = x >>> iter;
      y_shift  = y >>> iter;
      atan_ext = $signed({2'b00, bus.lut_atan});
      if (!z[33]) begin
         x_next = x - y_shift;
         y_next = y + x_shift;
         z_next = z - atan_ext;
      end else begin
         x_next = x + y_shift;
         y_next = y - x_shift;
         z_next = z + atan_ext;
      end
   end

   // The counter is forced back to 0 whenever RUN is left, so it can drive
   // lut_iter directly and still read 0 outside RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         x           <= '0;
         y           <= '0;
         z           <= '0;
         iter        <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         cos_r       <= '0;
         sin_r       <= '0;
         range_err_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  x           <= K_INIT;
                  y           <= '0;
                  z           <= angle_clamped;
                  range_err_r <= over_pos | over_neg;
                  iter        <= '0;
                  in_ready_r  <= 1'b0;
                  state       <= RUN;
               end
            end
            RUN: begin
               if (bus.abort) begin
                  iter       <= '0;
                  in_ready_r <= 1'b1;
                  state      <= IDLE;
               end else begin
                  x <= x_next;
                  y <= y_next;
                  z <= z_next;
                  if (iter == LAST) begin
                     cos_r       <= x_next;
                     sin_r       <= y_next;
                     out_valid_r <= 1'b1;
                     iter        <= '0;
                     state       <= DONE;
                  end else begin
                     iter <= iter + 5'd1;
                  end
               end
            end
            DONE: begin
               // abort and out_ready have the same effect here; with both
               // high the transfer is treated as completed.
               if (bus.out_ready || bus.abort) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               iter        <= '0;
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.cos_out   = cos_r;
   assign bus.sin_out   = sin_r;
   assign bus.range_err = range_err_r;
   assign bus.lut_iter  = iter;

endmodule
`default_nettype wire

// File: tb/tb_cordic_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_seq_ctrl
//  Description : Directed self-checking bench for cordic_seq_ctrl, with a
//                32-iteration and an 8-iteration instance sharing one clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_seq_ctrl;

   localparam longint ONE  = 64'sh100000000;
   localparam longint TOL  = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   cordic_seq_ctrl_if bus ();
   cordic_seq_ctrl_if bus8 ();

   cordic_seq_ctrl #(.ITERATIONS(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   cordic_seq_ctrl #(.ITERATIONS(8))  dut8 (.clk(clk), .rst(rst), .bus(bus8));

   // Arctangent table atan(2^-i) in Q0.32, combinational lookup.
   logic [31:0] atan_tab [32];
   assign bus.lut_atan  = atan_tab[bus.lut_iter];
   assign bus8.lut_atan = atan_tab[bus8.lut_iter];

   function automatic longint sval(input logic [33:0] v);
      return longint'($signed(v));
   endfunction

   function automatic longint absdiff(input logic [33:0] v, input longint e);
      longint d;
      d = sval(v) - e;
      return (d < 0) ? -d : d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_angle(input logic [33:0] a);
      bus.in_valid = 1'b1;
      bus.angle_in = a;
      tick();
      bus.in_valid = 1'b0;
   endtask

   // Counts cycles from the accept edge (first RUN cycle = 1) until out_valid.
   task automatic wait_valid(output int n);
      n = 1;
      while (!bus.out_valid && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      total++; if (bus.cos_out !== 34'h0) begin bad++; $display("FAIL reset_cos got=%h exp=0", bus.cos_out); end
      total++; if (bus.sin_out !== 34'h0) begin bad++; $display("FAIL reset_sin got=%h exp=0", bus.sin_out); end
      total++; if (bus.range_err !== 1'b0) begin bad++; $display("FAIL reset_range_err got=%b exp=0", bus.range_err); end
      total++; if (bus.lut_iter !== 5'd0) begin bad++; $display("FAIL reset_lut_iter got=%0d exp=0", bus.lut_iter); end
   endtask

   // Runs one angle through and checks latency, cos, sin, range_err.
   task automatic test_angle(input string nm, input logic [33:0] a,
                             input longint ec, input longint es, input logic er);
      int n;
      start_angle(a);
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL %s_in_ready_run got=%b exp=0", nm, bus.in_ready); end
      wait_valid(n);
      total++; if (n != 33) begin bad++; $display("FAIL %s_latency got=%0d exp=33", nm, n); end
      total++; if (absdiff(bus.cos_out, ec) > TOL) begin bad++; $display("FAIL %s_cos got=%0d exp=%0d", nm, sval(bus.cos_out), ec); end
      total++; if (absdiff(bus.sin_out, es) > TOL) begin bad++; $display("FAIL %s_sin got=%0d exp=%0d", nm, sval(bus.sin_out), es); end
      total++; if (bus.range_err !== er) begin bad++; $display("FAIL %s_range_err got=%b exp=%b", nm, bus.range_err, er); end
      drain();
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL %s_drain got=%b/%b exp=0/1", nm, bus.out_valid, bus.in_ready); end
   endtask

   task automatic test_back_to_back();
      int n;
      logic [33:0] sc, ss;
      start_angle(34'h0C90FDAA2);
      wait_valid(n);
      total++; if (n != 33) begin bad++; $display("FAIL bp_latency got=%0d exp=33", n); end
      sc = bus.cos_out;
      ss = bus.sin_out;
      for (int k = 0; k < 10; k++) begin
         bus.in_valid = k[0];
         bus.angle_in = 34'h0;
         tick();
         total++;
         if (bus.cos_out !== sc || bus.sin_out !== ss || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold cycle=%0d got cos=%h sin=%h ov=%b ir=%b exp cos=%h sin=%h ov=1 ir=0",
                     k, bus.cos_out, bus.sin_out, bus.out_valid, bus.in_ready, sc, ss);
         end
      end
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b/%b exp=0/1", bus.out_valid, bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_next_accept got=%b exp=0", bus.in_ready); end
      wait_valid(n);
      total++; if (n != 33 || absdiff(bus.cos_out, ONE) > TOL) begin bad++; $display("FAIL bp_next_result lat=%0d cos=%0d exp lat=33 cos=%0d", n, sval(bus.cos_out), ONE); end
      drain();
   endtask

   task automatic test_abort_run();
      logic [33:0] pc, ps;
      logic        seen;
      pc = bus.cos_out;
      ps = bus.sin_out;
      start_angle(34'h0C90FDAA2);
      for (int k = 0; k < 4; k++) tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.lut_iter !== 5'd0) begin bad++; $display("FAIL abort_idle got ir=%b ov=%b it=%0d exp 1/0/0", bus.in_ready, bus.out_valid, bus.lut_iter); end
      total++; if (bus.cos_out !== pc || bus.sin_out !== ps) begin bad++; $display("FAIL abort_keep got=%h/%h exp=%h/%h", bus.cos_out, bus.sin_out, pc, ps); end
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (bus.out_valid) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_result got=%b exp=0", seen); end
   endtask

   task automatic test_reset_mid();
      start_angle(34'h0C90FDAA2);
      for (int k = 0; k < 9; k++) tick();
      rst = 1'b1;
      #1;
      total++; if (bus.cos_out !== 34'h0 || bus.sin_out !== 34'h0) begin bad++; $display("FAIL rst_mid_out got=%h/%h exp=0/0", bus.cos_out, bus.sin_out); end
      total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.range_err !== 1'b0 || bus.lut_iter !== 5'd0) begin bad++; $display("FAIL rst_mid_ctl got ir=%b ov=%b re=%b it=%0d exp 1/0/0/0", bus.in_ready, bus.out_valid, bus.range_err, bus.lut_iter); end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_abort_done();
      int n;
      start_angle(34'h0);
      wait_valid(n);
      bus.abort = 1'b1;
      tick();
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL abort_done got=%b/%b exp=0/1", bus.out_valid, bus.in_ready); end
      // abort held in IDLE together with in_valid: the angle is still taken.
      start_angle(34'h0C90FDAA2);
      bus.abort = 1'b0;
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL abort_idle_accept got=%b exp=0", bus.in_ready); end
      wait_valid(n);
      total++; if (n != 33 || absdiff(bus.sin_out, 64'sh0B504F334) > TOL) begin bad++; $display("FAIL abort_idle_result lat=%0d sin=%0d exp lat=33 sin=%0d", n, sval(bus.sin_out), 64'sh0B504F334); end
      drain();
   endtask

   task automatic test_iter8();
      bus8.in_valid = 1'b1;
      bus8.angle_in = 34'h0;
      tick();
      bus8.in_valid = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         total++;
         if (bus8.lut_iter !== 5'(n - 1) || bus8.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL it8_run cycle=%0d got it=%0d ov=%b exp it=%0d ov=0", n, bus8.lut_iter, bus8.out_valid, n - 1);
         end
         tick();
      end
      total++; if (bus8.out_valid !== 1'b1 || bus8.lut_iter !== 5'd0) begin bad++; $display("FAIL it8_done got ov=%b it=%0d exp 1/0", bus8.out_valid, bus8.lut_iter); end
      bus8.out_ready = 1'b1;
      tick();
      bus8.out_ready = 1'b0;
      total++; if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin bad++; $display("FAIL it8_drain got=%b/%b exp=0/1", bus8.out_valid, bus8.in_ready); end
   endtask

   initial begin
      for (int i = 0; i < 32; i++)
         atan_tab[i] = 32'(longint'($atan(2.0 ** (-i)) * 4294967296.0));
      bus.in_valid   = 1'b0;
      bus.angle_in   = '0;
      bus.abort      = 1'b0;
      bus.out_ready  = 1'b0;
      bus8.in_valid  = 1'b0;
      bus8.angle_in  = '0;
      bus8.abort     = 1'b0;
      bus8.out_ready = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();

      test_reset();
      test_angle("zero",  34'h000000000, ONE, 0, 1'b0);
      test_angle("pi4",   34'h0C90FDAA2, 64'sh0B504F334, 64'sh0B504F334, 1'b0);
      test_angle("npi2",  -34'sh1921FB544, 0, -ONE, 1'b0);
      test_angle("oor_n", 34'h200000000, 0, -ONE, 1'b1);
      test_angle("oor_p", 34'h1FFFFFFFF, 0, ONE, 1'b1);
      test_back_to_back();
      test_abort_run();
      test_reset_mid();
      test_abort_done();
      test_iter8();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
